radial_zone_stream: RTL and testbench
=====================================

Name: radial_zone_stream

Overview:
- Streaming, pipelined radial zone selector for the DFDD pixel path.
- Tracks raster col/row of each accepted pixel and computes the exact squared distance to a programmable centre.
- Selects per-zone FP16 coefficient pair (a, b) plus zone index, and forwards the pixel payload alongside them.
- Zone table and centre are double-buffered: shadow registers are written any time; active registers swap only at frame start.

Parameters:
- NO_ZONES, 4, number of zones (>=2); zone NO_ZONES-1 is the innermost/default zone.
- COORD_W, 12, unsigned col/row/centre width.
- COEF_W, 16, a/b coefficient width (FP16 bit patterns, opaque to this block).
- PIX_W, 16, pass-through pixel payload width.
- D2_W, 2*COORD_W+1, derived (localparam), squared-distance and threshold width.
- ZI_W, $clog2(NO_ZONES), derived (localparam), zone index width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- cfg_we_i  in  1  write one shadow zone entry
- cfg_zone_i  in  ZI_W  zone to write
- cfg_a_i  in  COEF_W  shadow a
- cfg_b_i  in  COEF_W  shadow b
- cfg_r2_i  in  D2_W  shadow threshold (ignored for zone NO_ZONES-1)
- cfg_col_center_i  in  COORD_W  shadow centre col, sampled on cfg_commit_i
- cfg_row_center_i  in  COORD_W  shadow centre row, sampled on cfg_commit_i
- cfg_commit_i  in  1  request shadow->active swap at next frame start
- cfg_pending_o  out  1  commit requested, not yet applied
- s_valid_i  in  1  input beat valid
- s_ready_o  out  1  input beat accepted when valid&ready
- s_sof_i  in  1  beat is first pixel of frame
- s_eol_i  in  1  beat is last pixel of line
- s_data_i  in  PIX_W  pixel payload
- m_valid_o  out  1  output valid
- m_ready_i  in  1  downstream ready
- m_data_o  out  PIX_W  payload, delayed
- m_sof_o, m_eol_o  out  1 each  markers, delayed
- m_a_o  out  COEF_W  selected a
- m_b_o  out  COEF_W  selected b
- m_zone_o  out  ZI_W  selected zone index

Behaviour:
- Reset (asynchronous, rst_n_i low): all outputs 0, m_valid_o=0, cfg_pending_o=0, col/row counters 0, all shadow and active registers 0. A mid-frame reset drops in-flight beats; the next frame must start with sof.
- Handshake: advance = m_ready_i | ~m_valid_o; s_ready_o = advance; the entire pipeline stalls when advance=0. m_* outputs are held stable while m_valid_o & ~m_ready_i.
- Coordinates of each accepted beat:
  - sof beat: (0,0).
  - Otherwise: col = previous col+1, same row; after an eol beat the next beat is (0, row+1).
  - Counters wrap modulo 2^COORD_W silently.
- Pipeline, latency 3 accepted-to-valid when unstalled, throughput 1 beat/cycle:
  - S1: dc = col - ccol, dr = row - crow, signed COORD_W+1.
  - S2: d2 = dc*dc + dr*dr, unsigned D2_W, exact (no truncation).
  - S3: zone = NO_ZONES-1; for z = 0..NO_ZONES-2 ascending, if d2 >= r2[z] then zone = z (last match wins). a/b taken from the active table at that zone.
- Config:
  - cfg_we_i writes the shadow entry the same cycle.
  - cfg_commit_i sets pending and captures the centre into shadow.
  - When pending and an sof beat is accepted, active <= shadow (including any cfg_we_i write in that same cycle), pending clears, and the sof beat uses the new table.
  - Commit asserted in the same cycle as an accepted sof also applies to that frame.
  - Active values are captured per beat at S1 and carried down the pipeline, so a swap never affects beats already in flight.
- After reset (all r2=0), every pixel selects zone NO_ZONES-2.

Decomposition:
- Package dfdd_radial_pkg: zone_cfg_t struct {a, b, r2}, and the D2_W/ZI_W width functions.
- Sub-module radial_zone_select: combinational S3 compare/select over NO_ZONES. The top level holds the counters, config banks and pipeline registers.

Test Plan (NO_ZONES=3, COORD_W=12, centre (4,3), r2[0]=4, r2[1]=16, a=0x3C00/0x4000/0x4200, b=0x3800/0x3A00/0x3C00):
- Commit, then stream a 10-pixel line (sof on first) -> pixel (4,3) gives zone 2 / a=0x4200; (6,3) d2=4 gives zone 0; first output appears 3 cycles after first accept.
- Two lines with eol; pixel (8,6)... -> second line first beat at coords (0,1): d2=20 gives zone 1, a=0x4000; pixel (9,1) d2=29 gives zone 1.
- Hold m_ready_i low 5 cycles mid-stream -> s_ready_o=0, outputs stable, no beat lost or duplicated (scoreboard compare).
- Write new r2[0]=1 and commit mid-frame -> cfg_pending_o=1 and the current frame is unchanged; next sof frame shows (5,3) d2=1 as zone 0; pending clears on that sof accept.
- Centre (0,0), pixel at (4095,4095) -> d2=33538050 with no overflow; zone 1.
- Assert rst_n_i mid-frame with beats in flight -> m_valid_o=0 immediately, pending=0, and the table reads all-zero (zone 1 for any pixel).

Source files
------------

// File: rtl/dfdd_radial_pkg.sv
// Shared types and width helpers for the radial zone selector.
//   d2_width(coord_w) : width of an exact squared distance of two signed
//                       (coord_w+1)-bit differences
//   zi_width(n)       : zone index width for n zones
//   zone_cfg_t        : one zone table entry at the default widths
//                       (COEF_W=16, COORD_W=12)
package dfdd_radial_pkg;

  function automatic int d2_width(input int coord_w);
    return 2 * coord_w + 1;
  endfunction

  function automatic int zi_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_COEF_W  = 16;
  localparam int DEF_COORD_W = 12;
  localparam int DEF_D2_W    = d2_width(DEF_COORD_W);

  typedef struct packed {
    logic [DEF_COEF_W-1:0] a;
    logic [DEF_COEF_W-1:0] b;
    logic [DEF_D2_W-1:0]   r2;
  } zone_cfg_t;

endpackage

// File: rtl/radial_zone_select.sv
// Combinational zone compare/select (third pipeline stage).
//   d2_i   : squared distance of the beat
//   r2_i   : thresholds for zones 0..NO_ZONES-2
//   a_i/b_i: coefficient pairs for all zones
//   zone_o : selected zone; NO_ZONES-1 when no threshold matches
//   a_o/b_o: coefficient pair of the selected zone
module radial_zone_select
  import dfdd_radial_pkg::*;
#(
  parameter  int NO_ZONES = 4,
  parameter  int COEF_W   = 16,
  parameter  int D2_W     = 25,
  localparam int ZI_W     = zi_width(NO_ZONES)
) (
  input  logic [D2_W-1:0]                   d2_i,
  input  logic [NO_ZONES-2:0][D2_W-1:0]     r2_i,
  input  logic [NO_ZONES-1:0][COEF_W-1:0]   a_i,
  input  logic [NO_ZONES-1:0][COEF_W-1:0]   b_i,
  output logic [ZI_W-1:0]                   zone_o,
  output logic [COEF_W-1:0]                 a_o,
  output logic [COEF_W-1:0]                 b_o
);

  // Ascending scan, last match wins: thresholds need not be monotonic.
  always_comb begin
    zone_o = ZI_W'(NO_ZONES - 1);
    a_o    = a_i[NO_ZONES-1];
    b_o    = b_i[NO_ZONES-1];
    for (int unsigned z = 0; z < NO_ZONES - 1; z++) begin
      if (d2_i >= r2_i[z]) begin
        zone_o = ZI_W'(z);
        a_o    = a_i[z];
        b_o    = b_i[z];
      end
    end
  end

endmodule

// File: rtl/radial_zone_stream.sv
// Streaming radial zone selector for the DFDD pixel path.
// Tracks raster col/row of each accepted beat, computes the exact squared
// distance to a programmable centre, and attaches the zone index and its
// FP16 coefficient pair (a, b) to the delayed pixel payload.
// Ports:
//   clk_i, rst_n_i           : clock, async active-low reset
//   cfg_we_i/zone/a/b/r2     : shadow zone entry write
//   cfg_col/row_center_i     : shadow centre, captured on cfg_commit_i
//   cfg_commit_i             : request shadow->active swap at next sof
//   cfg_pending_o            : commit requested, not yet applied
//   s_*                      : input beat stream (valid/ready, sof, eol)
//   m_*                      : output beat stream with a, b, zone
// Latency 3 cycles, one beat per cycle, whole pipeline stalls together.
module radial_zone_stream
  import dfdd_radial_pkg::*;
#(
  parameter  int NO_ZONES = 4,
  parameter  int COORD_W  = 12,
  parameter  int COEF_W   = 16,
  parameter  int PIX_W    = 16,
  localparam int D2_W     = d2_width(COORD_W),
  localparam int ZI_W     = zi_width(NO_ZONES)
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               cfg_we_i,
  input  logic [ZI_W-1:0]    cfg_zone_i,
  input  logic [COEF_W-1:0]  cfg_a_i,
  input  logic [COEF_W-1:0]  cfg_b_i,
  input  logic [D2_W-1:0]    cfg_r2_i,
  input  logic [COORD_W-1:0] cfg_col_center_i,
  input  logic [COORD_W-1:0] cfg_row_center_i,
  input  logic               cfg_commit_i,
  output logic               cfg_pending_o,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic               s_sof_i,
  input  logic               s_eol_i,
  input  logic [PIX_W-1:0]   s_data_i,
  output logic               m_valid_o,
  input  logic               m_ready_i,
  output logic [PIX_W-1:0]   m_data_o,
  output logic               m_sof_o,
  output logic               m_eol_o,
  output logic [COEF_W-1:0]  m_a_o,
  output logic [COEF_W-1:0]  m_b_o,
  output logic [ZI_W-1:0]    m_zone_o
);

  typedef logic [NO_ZONES-1:0][COEF_W-1:0] coef_arr_t;
  typedef logic [NO_ZONES-2:0][D2_W-1:0]   r2_arr_t;
  typedef struct packed {
    coef_arr_t a;
    coef_arr_t b;
    r2_arr_t   r2;
  } tab_t;

  logic advance, accept, swap;

  // Config banks
  tab_t               sh_tab_q, sh_tab_d, act_tab_q, act_tab_d;
  logic [COORD_W-1:0] sh_ccol_q, sh_ccol_d, sh_crow_q, sh_crow_d;
  logic [COORD_W-1:0] act_ccol_q, act_ccol_d, act_crow_q, act_crow_d;
  logic               pend_q, pend_d;

  // Raster position of the next non-sof beat
  logic [COORD_W-1:0] nxt_col_q, nxt_col_d, nxt_row_q, nxt_row_d;
  logic [COORD_W-1:0] cur_col, cur_row;

  // Stage 1
  logic               v1_q;
  logic [COORD_W:0]   dc_d, dr_d, dc_q, dr_q;
  tab_t               tab1_q;
  logic [PIX_W-1:0]   data1_q;
  logic               sof1_q, eol1_q;

  // Stage 2
  logic               v2_q;
  logic [D2_W-1:0]    dcx, drx, d2_d, d2_q;
  tab_t               tab2_q;
  logic [PIX_W-1:0]   data2_q;
  logic               sof2_q, eol2_q;

  // Stage 3 (output registers)
  logic               m_valid_q, m_sof_q, m_eol_q;
  logic [PIX_W-1:0]   m_data_q;
  logic [COEF_W-1:0]  m_a_q, m_b_q, sel_a, sel_b;
  logic [ZI_W-1:0]    m_zone_q, sel_zone;

  assign advance = m_ready_i | ~m_valid_q;
  assign accept  = s_valid_i & advance;

  // Shadow next-state includes this cycle's write/commit so that a swap on
  // the same cycle picks them up; the sof beat then reads the swapped bank.
  always_comb begin
    sh_tab_d  = sh_tab_q;
    sh_ccol_d = sh_ccol_q;
    sh_crow_d = sh_crow_q;
    for (int unsigned z = 0; z < NO_ZONES; z++) begin
      if (cfg_we_i && (cfg_zone_i == ZI_W'(z))) begin
        sh_tab_d.a[z] = cfg_a_i;
        sh_tab_d.b[z] = cfg_b_i;
      end
    end
    for (int unsigned z = 0; z < NO_ZONES - 1; z++) begin
      if (cfg_we_i && (cfg_zone_i == ZI_W'(z))) begin
        sh_tab_d.r2[z] = cfg_r2_i;
      end
    end
    if (cfg_commit_i) begin
      sh_ccol_d = cfg_col_center_i;
      sh_crow_d = cfg_row_center_i;
    end

    swap = accept & s_sof_i & (pend_q | cfg_commit_i);
    if (swap) begin
      act_tab_d  = sh_tab_d;
      act_ccol_d = sh_ccol_d;
      act_crow_d = sh_crow_d;
    end else begin
      act_tab_d  = act_tab_q;
      act_ccol_d = act_ccol_q;
      act_crow_d = act_crow_q;
    end

    if (swap) begin
      pend_d = 1'b0;
    end else if (cfg_commit_i) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  always_comb begin
    cur_col   = s_sof_i ? '0 : nxt_col_q;
    cur_row   = s_sof_i ? '0 : nxt_row_q;
    nxt_col_d = nxt_col_q;
    nxt_row_d = nxt_row_q;
    if (accept) begin
      if (s_eol_i) begin
        nxt_col_d = '0;
        nxt_row_d = cur_row + 1'b1;
      end else begin
        nxt_col_d = cur_col + 1'b1;
        nxt_row_d = cur_row;
      end
    end
    dc_d = {1'b0, cur_col} - {1'b0, act_ccol_d};
    dr_d = {1'b0, cur_row} - {1'b0, act_crow_d};
  end

  // Sign-extend to D2_W; each square is below 2^(2*COORD_W), so the
  // D2_W-bit product and sum are exact.
  always_comb begin
    dcx  = {{(D2_W-COORD_W-1){dc_q[COORD_W]}}, dc_q};
    drx  = {{(D2_W-COORD_W-1){dr_q[COORD_W]}}, dr_q};
    d2_d = dcx * dcx + drx * drx;
  end

  radial_zone_select #(
    .NO_ZONES (NO_ZONES),
    .COEF_W   (COEF_W),
    .D2_W     (D2_W)
  ) u_select (
    .d2_i   (d2_q),
    .r2_i   (tab2_q.r2),
    .a_i    (tab2_q.a),
    .b_i    (tab2_q.b),
    .zone_o (sel_zone),
    .a_o    (sel_a),
    .b_o    (sel_b)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sh_tab_q   <= '0;
      sh_ccol_q  <= '0;
      sh_crow_q  <= '0;
      act_tab_q  <= '0;
      act_ccol_q <= '0;
      act_crow_q <= '0;
      pend_q     <= 1'b0;
      nxt_col_q  <= '0;
      nxt_row_q  <= '0;
    end else begin
      sh_tab_q   <= sh_tab_d;
      sh_ccol_q  <= sh_ccol_d;
      sh_crow_q  <= sh_crow_d;
      act_tab_q  <= act_tab_d;
      act_ccol_q <= act_ccol_d;
      act_crow_q <= act_crow_d;
      pend_q     <= pend_d;
      nxt_col_q  <= nxt_col_d;
      nxt_row_q  <= nxt_row_d;
    end
  end

  // Active table is copied per beat into S1 and carried along, so a later
  // swap cannot disturb beats already in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1_q      <= 1'b0;
      dc_q      <= '0;
      dr_q      <= '0;
      tab1_q    <= '0;
      data1_q   <= '0;
      sof1_q    <= 1'b0;
      eol1_q    <= 1'b0;
      v2_q      <= 1'b0;
      d2_q      <= '0;
      tab2_q    <= '0;
      data2_q   <= '0;
      sof2_q    <= 1'b0;
      eol2_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
      m_zone_q  <= '0;
    end else if (advance) begin
      v1_q      <= accept;
      dc_q      <= dc_d;
      dr_q      <= dr_d;
      tab1_q    <= act_tab_d;
      data1_q   <= s_data_i;
      sof1_q    <= s_sof_i;
      eol1_q    <= s_eol_i;
      v2_q      <= v1_q;
      d2_q      <= d2_d;
      tab2_q    <= tab1_q;
      data2_q   <= data1_q;
      sof2_q    <= sof1_q;
      eol2_q    <= eol1_q;
      m_valid_q <= v2_q;
      m_data_q  <= data2_q;
      m_sof_q   <= sof2_q;
      m_eol_q   <= eol2_q;
      m_a_q     <= sel_a;
      m_b_q     <= sel_b;
      m_zone_q  <= sel_zone;
    end
  end

  assign s_ready_o     = advance;
  assign cfg_pending_o = pend_q;
  assign m_valid_o     = m_valid_q;
  assign m_data_o      = m_data_q;
  assign m_sof_o       = m_sof_q;
  assign m_eol_o       = m_eol_q;
  assign m_a_o         = m_a_q;
  assign m_b_o         = m_b_q;
  assign m_zone_o      = m_zone_q;

endmodule

// File: tb/tb_radial_zone_stream.sv
module tb_radial_zone_stream;
  import dfdd_radial_pkg::*;

  localparam int NZ   = 3;
  localparam int CW   = 12;
  localparam int CF   = 16;
  localparam int PW   = 16;
  localparam int D2W  = d2_width(CW);
  localparam int ZIW  = zi_width(NZ);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_we = 1'b0;
  logic [ZIW-1:0]  cfg_zone = '0;
  logic [CF-1:0]   cfg_a = '0, cfg_b = '0;
  logic [D2W-1:0]  cfg_r2 = '0;
  logic [CW-1:0]   cfg_ccol = '0, cfg_crow = '0;
  logic            cfg_commit = 1'b0;
  logic            cfg_pending;
  logic            s_valid = 1'b0, s_ready, s_sof = 1'b0, s_eol = 1'b0;
  logic [PW-1:0]   s_data = '0;
  logic            m_valid, m_ready = 1'b1, m_sof, m_eol;
  logic [PW-1:0]   m_data;
  logic [CF-1:0]   m_a, m_b;
  logic [ZIW-1:0]  m_zone;

  radial_zone_stream #(
    .NO_ZONES (NZ),
    .COORD_W  (CW),
    .COEF_W   (CF),
    .PIX_W    (PW)
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .cfg_we_i         (cfg_we),
    .cfg_zone_i       (cfg_zone),
    .cfg_a_i          (cfg_a),
    .cfg_b_i          (cfg_b),
    .cfg_r2_i         (cfg_r2),
    .cfg_col_center_i (cfg_ccol),
    .cfg_row_center_i (cfg_crow),
    .cfg_commit_i     (cfg_commit),
    .cfg_pending_o    (cfg_pending),
    .s_valid_i        (s_valid),
    .s_ready_o        (s_ready),
    .s_sof_i          (s_sof),
    .s_eol_i          (s_eol),
    .s_data_i         (s_data),
    .m_valid_o        (m_valid),
    .m_ready_i        (m_ready),
    .m_data_o         (m_data),
    .m_sof_o          (m_sof),
    .m_eol_o          (m_eol),
    .m_a_o            (m_a),
    .m_b_o            (m_b),
    .m_zone_o         (m_zone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [PW-1:0]  data;
    logic           sof;
    logic           eol;
    logic [CF-1:0]  a;
    logic [CF-1:0]  b;
    logic [ZIW-1:0] zone;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int failures = 0;
  int first_acc = -1;
  int first_out = -1;

  // Reference model state
  zone_cfg_t sh_m[NZ];
  zone_cfg_t ac_m[NZ];
  int sh_cc = 0, sh_cr = 0, ac_cc = 0, ac_cr = 0;
  bit pend_m = 1'b0;
  int nxt_c = 0, nxt_r = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NZ; i++) begin
      sh_m[i] = '0;
      ac_m[i] = '0;
    end
    sh_cc = 0; sh_cr = 0; ac_cc = 0; ac_cr = 0;
    pend_m = 1'b0;
    nxt_c = 0; nxt_r = 0;
  endtask

  // Hand-derived zones for selected coordinates; -1 defers to the model.
  function automatic int hand_zone(input int phase, input int c, input int r);
    case (phase)
      1: begin
        if (c == 0 && r == 0) return 1;   // d2=25
        if (c == 0 && r == 1) return 1;   // d2=20
        if (c == 9 && r == 1) return 1;   // d2=29
        if (c == 4 && r == 3) return 2;   // d2=0
        if (c == 5 && r == 3) return 2;   // d2=1 < r2[0]=4
        if (c == 6 && r == 3) return 0;   // d2=4
      end
      2: begin
        if (c == 5 && r == 3) return 0;   // d2=1 >= r2[0]=1
        if (c == 4 && r == 3) return 2;
        if (c == 6 && r == 3) return 0;
      end
      3: return 1;                        // all-zero table
      4: begin
        if (c == 0 && r == 0) return 2;
        if (c == 4095 && r == 4095) return 1;  // d2=33538050
      end
      default: ;
    endcase
    return -1;
  endfunction

  task automatic model_accept(input logic [PW-1:0] d, input bit sof, input bit eol, input int phase);
    int col, row, z, hz;
    longint dc, dr, d2;
    if (sof && pend_m) begin
      ac_m = sh_m;
      ac_cc = sh_cc;
      ac_cr = sh_cr;
      pend_m = 1'b0;
    end
    col = sof ? 0 : nxt_c;
    row = sof ? 0 : nxt_r;
    dc = longint'(col) - longint'(ac_cc);
    dr = longint'(row) - longint'(ac_cr);
    d2 = dc * dc + dr * dr;
    z = NZ - 1;
    for (int k = 0; k < NZ - 1; k++)
      if (d2 >= longint'(ac_m[k].r2)) z = k;
    hz = hand_zone(phase, col, row);
    if (hz >= 0) z = hz;
    sb.push_back('{data: d, sof: sof, eol: eol, a: ac_m[z].a, b: ac_m[z].b, zone: ZIW'(z)});
    if (eol) begin
      nxt_c = 0;
      nxt_r = (row + 1) % 4096;
    end else begin
      nxt_c = (col + 1) % 4096;
      nxt_r = row;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [PW-1:0] d, input bit sof, input bit eol, input int phase);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_sof = sof; s_eol = eol;
    #1;
    while (!s_ready) begin
      @(negedge clk); #1;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL send_timeout: s_ready_o stuck at 0 expected 1");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
      end
    end
    if (first_acc < 0) first_acc = cyc;
    model_accept(d, sof, eol, phase);
    @(negedge clk);
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
  endtask

  task automatic send_lines(input int row0, input int nlines, input int ncols, input bit with_sof, input int phase);
    for (int r = 0; r < nlines; r++) begin
      for (int c = 0; c < ncols; c++) begin
        bit sof;
        sof = with_sof && r == 0 && c == 0;
        send(PW'((phase << 12) | ((row0 + r) << 5) | c), sof, c == ncols - 1, phase);
        if (sof) chk("pend_clear_on_sof", 64'(cfg_pending), 64'(0));
      end
    end
  endtask

  task automatic cfg_write(input int z, input logic [CF-1:0] a, input logic [CF-1:0] b, input logic [D2W-1:0] r2);
    cfg_we = 1'b1; cfg_zone = ZIW'(z); cfg_a = a; cfg_b = b; cfg_r2 = r2;
    @(negedge clk);
    cfg_we = 1'b0;
    sh_m[z].a = a;
    sh_m[z].b = b;
    if (z < NZ - 1) sh_m[z].r2 = r2;
  endtask

  task automatic cfg_do_commit(input int cc, input int cr);
    cfg_ccol = CW'(cc); cfg_crow = CW'(cr); cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    sh_cc = cc; sh_cr = cr; pend_m = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'(0));
  endtask

  // Holds m_ready low for 5 cycles; outputs must freeze and input must stall.
  task automatic stall5();
    logic [63:0] snap;
    m_ready = 1'b0;
    #2;
    chk("stall_valid", 64'(m_valid), 64'(1));
    snap = 64'({m_data, m_sof, m_eol, m_a, m_b, m_zone});
    chk("stall_s_ready", 64'(s_ready), 64'(0));
    repeat (4) begin
      @(negedge clk); #2;
      chk("stall_s_ready", 64'(s_ready), 64'(0));
      chk("stall_hold", 64'({m_data, m_sof, m_eol, m_a, m_b, m_zone}), snap);
    end
    @(negedge clk);
    m_ready = 1'b1;
  endtask

  // Monitor: pops one expectation per completed output transfer.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk); #2;
      if (rst_n && m_valid && m_ready) begin
        if (first_out < 0) first_out = cyc;
        if (sb.size() == 0) begin
          chk("unexpected_beat", 64'(m_data), 64'hDEAD_BEEF);
        end else begin
          e = sb.pop_front();
          chk("out_data", 64'(m_data), 64'(e.data));
          chk("out_marks", 64'({m_sof, m_eol}), 64'({e.sof, e.eol}));
          chk("out_zone", 64'(m_zone), 64'(e.zone));
          chk("out_a", 64'(m_a), 64'(e.a));
          chk("out_b", 64'(m_b), 64'(e.b));
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_m_valid", 64'(m_valid), 64'(0));
    chk("rst_pending", 64'(cfg_pending), 64'(0));
    chk("rst_m_data", 64'(m_data), 64'(0));
    chk("rst_m_zone", 64'(m_zone), 64'(0));
    chk("rst_m_ab", 64'({m_a, m_b}), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(1));
    rst_n = 1'b1;
    @(negedge clk);

    cfg_write(0, 16'h3C00, 16'h3800, 25'd4);
    cfg_write(1, 16'h4000, 16'h3A00, 25'd16);
    cfg_write(2, 16'h4200, 16'h3C00, 25'd0);
    cfg_do_commit(4, 3);
    chk("pending_set", 64'(cfg_pending), 64'(1));

    fork
      send_lines(0, 4, 10, 1'b1, 1);
      begin
        repeat (15) @(negedge clk);
        stall5();
      end
    join
    drain();
    chk("first_latency", 64'(first_out - first_acc), 64'(3));

    // Mid-frame commit must not disturb the current frame.
    send_lines(0, 2, 10, 1'b1, 1);
    cfg_write(0, 16'h3C00, 16'h3800, 25'd1);
    cfg_do_commit(4, 3);
    chk("midframe_pending", 64'(cfg_pending), 64'(1));
    send_lines(2, 2, 10, 1'b0, 1);
    drain();
    chk("pending_held", 64'(cfg_pending), 64'(1));
    send_lines(0, 4, 10, 1'b1, 2);
    drain();

    // Far corner with centre at the origin.
    cfg_do_commit(0, 0);
    send(16'h1000, 1'b1, 1'b1, 4);
    for (int i = 0; i < 4094; i++) send(PW'(i), 1'b0, 1'b1, 4);
    for (int i = 0; i < 4096; i++) send(PW'(i), 1'b0, i == 4095, 4);
    drain();

    // Reset with beats in flight and a commit pending.
    send(16'h0A01, 1'b1, 1'b0, 0);
    cfg_ccol = 12'd7; cfg_crow = 12'd7; cfg_commit = 1'b1;
    send(16'h0A02, 1'b0, 1'b0, 0);
    cfg_commit = 1'b0;
    sh_cc = 7; sh_cr = 7; pend_m = 1'b1;
    send(16'h0A03, 1'b0, 1'b0, 0);
    chk("pre_rst_valid", 64'(m_valid), 64'(1));
    chk("pre_rst_pending", 64'(cfg_pending), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(m_valid), 64'(0));
    chk("mid_rst_pending", 64'(cfg_pending), 64'(0));
    chk("mid_rst_zone_ab", 64'({m_zone, m_a, m_b}), 64'(0));
    sb.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_lines(0, 2, 5, 1'b1, 3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
